// File: rtl/sprite_line_eval_if.sv
// Signal bundle between the sprite evaluator and its neighbours: the line sequencer,
// the sprite RAM read port and the sprite draw stage's line list.
interface sprite_line_eval_if #(
  parameter int ADDR_WIDTH   = 6,
  parameter int MAX_PER_LINE = 8,
  parameter int POS_BIT      = 10
);
  localparam int IDX_W = $clog2(MAX_PER_LINE);

  logic                  line_start;
  logic [POS_BIT-1:0]    next_line_y;
  logic [ADDR_WIDTH-1:0] oam_rd_addr;
  logic [31:0]           oam_rd_data;
  logic                  lst_we;
  logic [IDX_W-1:0]      lst_idx;
  logic [25:0]           lst_data;
  logic                  busy;
  logic                  done;
  logic [IDX_W:0]        sprite_cnt;
  logic                  overflow;

  modport slave (
    input  line_start, next_line_y, oam_rd_data,
    output oam_rd_addr, lst_we, lst_idx, lst_data, busy, done, sprite_cnt, overflow
  );

  modport master (
    output line_start, next_line_y, oam_rd_data,
    input  oam_rd_addr, lst_we, lst_idx, lst_data, busy, done, sprite_cnt, overflow
  );
endinterface

// File: rtl/sprite_line_eval.sv
// Per-scanline sprite evaluator: scans every sprite RAM entry in index order and
// writes the first MAX_PER_LINE sprites covering the next line into the line list.
module sprite_line_eval #(
  parameter int ADDR_WIDTH   = 6,
  parameter int MAX_PER_LINE = 8,
  parameter int POS_BIT      = 10,
  parameter int ROW_BIT      = 4
) (
  input  logic               clk_25p2MHz,
  input  logic               rst,
  sprite_line_eval_if.slave  bus
);
  localparam int IDX_W = $clog2(MAX_PER_LINE);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(MAX_PER_LINE);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_e;

  state_e                state_q, state_d;
  logic [POS_BIT-1:0]    line_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rd_valid_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ovf_q;
  logic                  done_q;
  logic                  we_q;
  logic [IDX_W-1:0]      idx_q;
  logic [25:0]           data_q;

  logic [POS_BIT-1:0] spr_y, spr_x;
  logic [7:0]         spr_tile;
  logic [3:0]         spr_attr;
  logic [POS_BIT:0]   y_end;
  logic [ROW_BIT-1:0] row;
  logic               hit;

  assign spr_y    = bus.oam_rd_data[31:22];
  assign spr_x    = bus.oam_rd_data[21:12];
  assign spr_tile = bus.oam_rd_data[11:4];
  assign spr_attr = bus.oam_rd_data[3:0];

  // One extra bit on the bottom edge keeps sprites near the screen bottom from wrapping.
  assign y_end = {1'b0, spr_y} + (POS_BIT+1)'(1 << ROW_BIT);
  assign hit   = spr_attr[3] && (spr_y <= line_q) && ({1'b0, line_q} < y_end);
  assign row   = line_q[ROW_BIT-1:0] - spr_y[ROW_BIT-1:0];

  always_ff @(posedge clk_25p2MHz) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: state_d gets a default before any branch, so no path can infer a latch.
    state_d = state_q;
    if (bus.line_start) begin
      state_d = SCAN;
    end else begin
      case (state_q)
        SCAN:    if (addr_q == LAST_ADDR) state_d = FLUSH;
        FLUSH:   state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bus.busy        = (state_q != IDLE);
    bus.done        = done_q;
    bus.oam_rd_addr = addr_q;
    bus.lst_we      = we_q;
    bus.lst_idx     = idx_q;
    bus.lst_data    = data_q;
    bus.sprite_cnt  = cnt_q;
    bus.overflow    = ovf_q;
  end

  // rd_valid_q marks cycles where oam_rd_data belongs to an address issued by the current scan.
  always_ff @(posedge clk_25p2MHz) begin
    if (rst) begin
      line_q     <= '0;
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
    end else begin
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      rd_valid_q <= (state_q == SCAN);
      if (bus.line_start) begin
        line_q     <= bus.next_line_y;
        addr_q     <= '0;
        cnt_q      <= '0;
        ovf_q      <= 1'b0;
        rd_valid_q <= 1'b0;
      end else begin
        if (state_q == SCAN && addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
        if (state_q == FLUSH) done_q <= 1'b1;
        if (rd_valid_q && hit) begin
          if (cnt_q != CNT_MAX) begin
            we_q   <= 1'b1;
            idx_q  <= cnt_q[IDX_W-1:0];
            data_q <= {row, spr_x, spr_tile, spr_attr};
            cnt_q  <= cnt_q + 1'b1;
          end else begin
            ovf_q <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sprite_line_eval.sv
// Directed bench for sprite_line_eval: sync-read sprite RAM model, line-list write
// capture, a single-sprite vector table and hand-written multi-cycle sequences.
module tb_sprite_line_eval;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_line_eval_if #(.ADDR_WIDTH(6), .MAX_PER_LINE(8), .POS_BIT(10)) bus ();

  sprite_line_eval #(.ADDR_WIDTH(6), .MAX_PER_LINE(8), .POS_BIT(10), .ROW_BIT(4)) dut (
    .clk_25p2MHz (clk),
    .rst         (rst),
    .bus         (bus)
  );

  logic [31:0] mem [64];
  always @(posedge clk) bus.oam_rd_data <= mem[bus.oam_rd_addr];

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int done_rel = -1;

  typedef struct {
    logic [2:0]  idx;
    logic [25:0] data;
    int          rel;
  } wr_t;
  wr_t wq[$];

  typedef struct {
    int          idx;
    logic [31:0] word;
    logic [9:0]  line;
    bit          exp_hit;
    logic [25:0] exp_data;
  } vec_t;
  vec_t vecs[10];

  localparam logic [31:0] W100  = {10'd100, 10'd200, 8'h3C, 4'h8};
  localparam logic [31:0] W1020 = {10'd1020, 10'd5, 8'h01, 4'h9};
  localparam logic [31:0] W0    = {10'd0, 10'd1023, 8'hFF, 4'hF};
  localparam logic [31:0] WDIS  = {10'd100, 10'd200, 8'h3C, 4'h7};

  always @(posedge clk) cyc <= cyc + 1;

  // Capture line-list writes and done pulses shortly after each active edge.
  always @(posedge clk) begin
    #2;
    if (bus.lst_we) wq.push_back('{bus.lst_idx, bus.lst_data, cyc - start_cyc});
    if (bus.done) begin
      done_cnt++;
      done_rel = cyc - start_cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic load_ten();
    clear_mem();
    for (int i = 0; i < 10; i++)
      mem[3 + 4*i] = {10'd40, 10'(i*10), 8'(i), 4'h8};
  endtask

  task automatic start_line(input logic [9:0] y);
    @(negedge clk);
    wq.delete();
    done_cnt = 0;
    done_rel = -1;
    bus.line_start  = 1'b1;
    bus.next_line_y = y;
    start_cyc = cyc;
    @(negedge clk);
    bus.line_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done_seen"}, 32'(done_cnt != 0), 32'd1);
    check({tag, " done_latency"}, 32'(done_rel), 32'd66);
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    repeat (4) @(negedge clk);
    check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"},     32'(bus.busy),        32'd0);
    check({tag, " done"},     32'(bus.done),        32'd0);
    check({tag, " lst_we"},   32'(bus.lst_we),      32'd0);
    check({tag, " lst_idx"},  32'(bus.lst_idx),     32'd0);
    check({tag, " lst_data"}, 32'(bus.lst_data),    32'd0);
    check({tag, " cnt"},      32'(bus.sprite_cnt),  32'd0);
    check({tag, " ovf"},      32'(bus.overflow),    32'd0);
    check({tag, " rd_addr"},  32'(bus.oam_rd_addr), 32'd0);
  endtask

  task automatic check_ten(input string tag);
    check({tag, " cnt"},    32'(bus.sprite_cnt), 32'd8);
    check({tag, " ovf"},    32'(bus.overflow),   32'd1);
    check({tag, " writes"}, 32'(wq.size()),      32'd8);
    for (int j = 0; j < 8 && j < wq.size(); j++) begin
      check($sformatf("%s slot%0d idx", tag, j),  32'(wq[j].idx),  32'(j));
      check($sformatf("%s slot%0d data", tag, j), 32'(wq[j].data), 32'({4'd5, 10'(j*10), 8'(j), 4'h8}));
      check($sformatf("%s slot%0d time", tag, j), 32'(wq[j].rel),  32'(3 + 4*j + 3));
    end
  endtask

  initial begin
    vecs[0] = '{5,  W100,  10'd99,   1'b0, 26'h0};
    vecs[1] = '{5,  W100,  10'd100,  1'b1, {4'd0, 10'd200, 8'h3C, 4'h8}};
    vecs[2] = '{5,  W100,  10'd115,  1'b1, {4'd15, 10'd200, 8'h3C, 4'h8}};
    vecs[3] = '{5,  W100,  10'd116,  1'b0, 26'h0};
    vecs[4] = '{63, W1020, 10'd3,    1'b0, 26'h0};
    vecs[5] = '{63, W1020, 10'd1023, 1'b1, {4'd3, 10'd5, 8'h01, 4'h9}};
    vecs[6] = '{5,  WDIS,  10'd100,  1'b0, 26'h0};
    vecs[7] = '{0,  W0,    10'd0,    1'b1, {4'd0, 10'd1023, 8'hFF, 4'hF}};
    vecs[8] = '{0,  W0,    10'd15,   1'b1, {4'd15, 10'd1023, 8'hFF, 4'hF}};
    vecs[9] = '{0,  W0,    10'd16,   1'b0, 26'h0};

    bus.line_start  = 1'b0;
    bus.next_line_y = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // All entries disabled.
    start_line(10'd50);
    check("empty busy_after_start", 32'(bus.busy), 32'd1);
    wait_done("empty");
    check("empty cnt",    32'(bus.sprite_cnt), 32'd0);
    check("empty ovf",    32'(bus.overflow),   32'd0);
    check("empty writes", 32'(wq.size()),      32'd0);

    // Single-sprite vector table.
    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      clear_mem();
      mem[vecs[i].idx] = vecs[i].word;
      start_line(vecs[i].line);
      wait_done(tag);
      check({tag, " cnt"},    32'(bus.sprite_cnt), 32'(vecs[i].exp_hit));
      check({tag, " ovf"},    32'(bus.overflow),   32'd0);
      check({tag, " writes"}, 32'(wq.size()),      32'(vecs[i].exp_hit));
      if (vecs[i].exp_hit && wq.size() > 0) begin
        check({tag, " idx"},  32'(wq[0].idx),  32'd0);
        check({tag, " data"}, 32'(wq[0].data), 32'(vecs[i].exp_data));
        check({tag, " time"}, 32'(wq[0].rel),  32'(vecs[i].idx + 3));
      end
    end

    // Ten hits on one line: first eight in index order, then overflow.
    load_ten();
    start_line(10'd45);
    wait_done("ten");
    check_ten("ten");

    // Restart 20 cycles into a scan.
    clear_mem();
    mem[2] = {10'd5,  10'd7,   8'h11, 4'h8};
    mem[4] = {10'd50, 10'd300, 8'h22, 4'hA};
    mem[6] = {10'd58, 10'd400, 8'h33, 4'hC};
    start_line(10'd10);
    repeat (18) @(negedge clk);
    start_line(10'd60);
    wait_done("restart");
    check("restart cnt",    32'(bus.sprite_cnt), 32'd2);
    check("restart ovf",    32'(bus.overflow),   32'd0);
    check("restart writes", 32'(wq.size()),      32'd2);
    if (wq.size() == 2) begin
      check("restart slot0 data", 32'(wq[0].data), 32'({4'd10, 10'd300, 8'h22, 4'hA}));
      check("restart slot0 time", 32'(wq[0].rel),  32'd7);
      check("restart slot1 idx",  32'(wq[1].idx),  32'd1);
      check("restart slot1 data", 32'(wq[1].data), 32'({4'd2, 10'd400, 8'h33, 4'hC}));
      check("restart slot1 time", 32'(wq[1].rel),  32'd9);
    end

    // line_start arriving in the FLUSH cycle wins over done.
    clear_mem();
    mem[5] = W100;
    start_line(10'd50);
    repeat (63) @(negedge clk);
    check("flush busy", 32'(bus.busy), 32'd1);
    start_line(10'd100);
    wait_done("flush_restart");
    check("flush_restart cnt", 32'(bus.sprite_cnt), 32'd1);
    if (wq.size() > 0) begin
      check("flush_restart data", 32'(wq[0].data), 32'({4'd0, 10'd200, 8'h3C, 4'h8}));
      check("flush_restart time", 32'(wq[0].rel),  32'd8);
    end

    // Reset sampled at edge 30 of a scan.
    load_ten();
    start_line(10'd45);
    repeat (28) @(negedge clk);
    @(negedge clk);
    check("pre_reset cnt", 32'(bus.sprite_cnt), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid_reset");
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("mid_reset no_done", 32'(done_cnt), 32'd0);
    check("mid_reset idle",    32'(bus.busy), 32'd0);
    start_line(10'd45);
    wait_done("post_reset");
    check_ten("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
